// File: rtl/sub_word_sched.sv
// sub_word_sched: shares one external AES S-box core across the four bytes of a
// 32-bit word (SubWord / column-serial SubBytes), one byte per cycle.
// Optional feature macro: SUB_WORD_ROT_EN adds a 'rot' input that applies
// RotWord ahead of SubWord.
// SBOX_LAT is the core latency in cycles (0..3, 0 = combinational core).
module sub_word_sched #(
    parameter int SBOX_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
`ifdef SUB_WORD_ROT_EN
    input  logic        rot,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [7:0]  sbox_in,
    input  logic [7:0]  sbox_out,
    output logic        busy
);

    localparam logic [1:0] DRAIN_INIT = 2'((SBOX_LAT > 0) ? SBOX_LAT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] hold_q, hold_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  drain_q, drain_d;
    logic [31:0] out_word_q, out_word_d;

    logic        accept;
    logic        issuing;
    logic        rot_sel;
    logic [1:0]  dst_lane;
    logic [1:0]  src_lane;
    logic        cap_valid;
    logic [1:0]  cap_lane;

    assign accept   = in_valid && in_ready_q;
    assign issuing  = (state_q == S_ISSUE);

    // Destination lane walks 3..0; with rotation the source lane is one lane lower.
    always_comb begin
        dst_lane = 2'd3 - cnt_q;
        src_lane = rot_sel ? (dst_lane - 2'd1) : dst_lane;
        sbox_in  = issuing ? hold_q[{src_lane, 3'b000} +: 8] : 8'h00;
    end

`ifdef SUB_WORD_ROT_EN
    logic rot_q, rot_d;

    // Rotation request is sampled together with the word.
    always_comb begin
        rot_d = accept ? rot : rot_q;
    end

    // Rotation flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end

    assign rot_sel = rot_q;
`else
    assign rot_sel = 1'b0;
`endif

    generate
        if (SBOX_LAT == 0) begin : g_no_pipe
            assign cap_valid = issuing;
            assign cap_lane  = dst_lane;
        end else begin : g_tag_pipe
            logic [SBOX_LAT-1:0]      tag_valid_q, tag_valid_d;
            logic [SBOX_LAT-1:0][1:0] tag_lane_q, tag_lane_d;

            // Lane tags travel beside the bytes in flight inside the core.
            always_comb begin
                tag_valid_d    = '0;
                tag_lane_d     = '0;
                tag_valid_d[0] = issuing;
                tag_lane_d[0]  = dst_lane;
                for (int i = 1; i < SBOX_LAT; i++) begin
                    tag_valid_d[i] = tag_valid_q[i-1];
                    tag_lane_d[i]  = tag_lane_q[i-1];
                end
            end

            // Tag pipe register; clearing it on reset discards late core results.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid_q <= '0;
                    tag_lane_q  <= '0;
                end else begin
                    tag_valid_q <= tag_valid_d;
                    tag_lane_q  <= tag_lane_d;
                end
            end

            assign cap_valid = tag_valid_q[SBOX_LAT-1];
            assign cap_lane  = tag_lane_q[SBOX_LAT-1];
        end
    endgenerate

    // Next-state, issue counting, drain timing and result lane capture.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        out_word_d = out_word_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    hold_d  = in_word;
                    cnt_d   = 2'd0;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    if (SBOX_LAT > 0) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_INIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cap_valid) begin
            out_word_d[{cap_lane, 3'b000} +: 8] = sbox_out;
        end

        in_ready_d = (state_d == S_IDLE);
    end

    // Main state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            hold_q     <= 32'h0;
            cnt_q      <= 2'd0;
            drain_q    <= 2'd0;
            out_word_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            out_word_q <= out_word_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_DONE);
    assign out_word  = out_word_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/sub_word_sched.md
Name: sub_word_sched

Overview:
- Scheduler that shares one external composite-field AES S-box core (built around the GF(2^4) inverter) across the four bytes of a 32-bit word.
- Performs SubWord for key expansion and column-serial SubBytes.
- Accepts a word on a valid/ready input, issues one byte per cycle to the shared S-box, and reassembles the results into lanes.
- Presents the result on a valid/ready output.

Parameters:
SBOX_LAT, 1, cycles from sbox_in to the matching sbox_out; legal 0..3 (0 = combinational core)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_word  input  32  input word; lane3=[31:24] (AES byte a0) .. lane0=[7:0]
out_valid  output  1  result word valid
out_ready  input  1  downstream accepts result
out_word  output  32  SubWord result, same lane order
sbox_in  output  8  byte presented to the shared S-box core
sbox_out  input  8  S-box core result, SBOX_LAT cycles after sbox_in
busy  output  1  high in ISSUE, DRAIN, DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=0, out_valid=0, out_word=32'h0, sbox_in=8'h00, busy=0, issue counter=0, tag pipe cleared. The first cycle after rst deasserts: in_ready=1.
- in_ready is registered. It is 1 only in IDLE.
- Accept occurs on the edge where in_valid & in_ready. Capture in_word into hold_reg. Go to ISSUE and clear in_ready.
- ISSUE (4 cycles):
  - 2-bit issue counter n=0..3.
  - sbox_in = hold_reg lane (3-n), giving issue order lane3, lane2, lane1, lane0.
  - Each issued lane index is pushed into a tag shift pipe of depth SBOX_LAT (0 = pass-through).
  - After n=3, go to DRAIN if SBOX_LAT>0, else DONE.
- Outside ISSUE, sbox_in=8'h00 and no tag is pushed.
- Capture: a byte issued in cycle c appears on sbox_out in cycle c+SBOX_LAT. At the end of that cycle it is written into out_word at the lane carried by its tag.
- DRAIN: lasts SBOX_LAT cycles, until the last tag exits. Then go to DONE.
- Latency: accept at edge k gives ISSUE in cycles k+1..k+4. out_valid rises in cycle k+5+SBOX_LAT (k+6 at the default setting).
- DONE: out_valid=1 and out_word is stable. Both hold until out_valid & out_ready. On that edge: out_valid=0, state=IDLE, in_ready=1 the next cycle.
- There is no overlap between words. Throughput is one word per 6+SBOX_LAT cycles when out_ready is held high.
- in_valid while busy is ignored. in_word is sampled only at accept.
- out_ready while not out_valid has no effect.
- out_word is not cleared between words. Lanes are overwritten during capture. Consumers use out_word only while out_valid=1.
- Reset mid-operation: abort immediately, return to reset values, and drop any in-flight bytes. Late sbox_out values after reset are ignored because the tag pipe is cleared.

Optional Feature:
- Macro: SUB_WORD_ROT_EN
- When defined:
  - Extra input port rot (1 bit) is sampled at accept.
  - rot=1 applies RotWord before SubWord. The issue order becomes lane2, lane1, lane0, lane3, and the results are written to lanes 3, 2, 1, 0 in that order.
  - Result: out[31:24]=S(in[23:16]), out[23:16]=S(in[15:8]), out[15:8]=S(in[7:0]), out[7:0]=S(in[31:24]).
  - rot=0 gives plain SubWord.
- When undefined: no rot port; plain SubWord only.

Test Plan:
- Basic SubWord (SBOX_LAT=1, bench S-box model, out_ready=1): in_word=32'h000153FF accepted at edge k -> out_word=32'h637CED16; out_valid high in cycle k+6 for one cycle; sbox_in sequence 00,01,53,FF.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_word held at 32'h637CED16; in_ready=0 throughout; a second word accepted only the cycle after the out handshake.
- Busy-ignore: pulse in_valid with 32'hFFFFFFFF during ISSUE -> not accepted; the first word's result is unchanged.
- Latency sweep: SBOX_LAT=0 and SBOX_LAT=3 with in_word=32'h00000000 -> out_word=32'h63636363, with out_valid at k+5 and k+8 respectively.
- Reset mid-op: assert rst during the second ISSUE cycle -> all outputs immediately at reset values; after release, in_ready=1 next cycle; a new word 32'h01010101 -> 32'h7C7C7C7C with no stale lanes.
- SUB_WORD_ROT_EN: rot=1, in_word=32'h000153FF -> out_word=32'h7CED1663; rot=0 on the same word -> 32'h637CED16.
